// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared types and constants for the FIFO read-side stream checker
// Contents: checker state enum, throttle LFSR seed/taps, PRBS tap masks per data width.
package fifo_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Throttle: Fibonacci x^8+x^6+x^5+x^4+1, shifting left; feedback from bits 7,5,4,3.
    localparam logic [7:0] THR_SEED = 8'hA5;
    localparam logic [7:0] THR_TAPS = 8'hB8;

    // Right-shifting Galois masks for the expected-data PRBS.
    function automatic logic [63:0] prbs_taps(input int dw);
        case (dw)
            8:       return 64'h0000_0000_0000_00B8;
            16:      return 64'h0000_0000_0000_B400;
            24:      return 64'h0000_0000_00E1_0000;
            32:      return 64'h0000_0000_8020_0003;
            default: return 64'h1 << (dw - 1);
        endcase
    endfunction

endpackage

// File: rtl/fifo_lfsr.sv
// rtl/fifo_lfsr.sv - parameterised LFSR with synchronous load and advance
// Ports: clk_i/rst_ni clock and async active-low reset; load_i reloads SEED;
//        adv_i steps once; state_o current register value.
// GALOIS=0 selects a left-shifting Fibonacci form, GALOIS=1 a right-shifting Galois form.
module fifo_lfsr #(
    parameter int             W      = 8,
    parameter logic [W-1:0]   TAPS   = '1,
    parameter logic [W-1:0]   SEED   = '1,
    parameter bit             GALOIS = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         adv_i,
    output logic [W-1:0] state_o
);

    logic [W-1:0] state_q;
    logic [W-1:0] state_step;

    always_comb begin
        state_step = state_q;
        if (GALOIS) begin
            state_step = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
        end else begin
            state_step = {state_q[W-2:0], ^(state_q & TAPS)};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEED;
        end else if (load_i) begin
            state_q <= SEED;
        end else if (adv_i) begin
            state_q <= state_step;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/fifo_stream_checker.sv
// rtl/fifo_stream_checker.sv - read-side FIFO traffic checker with random throttle and error capture
// Ports: clk_i, rst_ni (async active-low); start_i/count_i/rate_i run control;
//        rd_en_o/rd_data_i/empty_i FIFO read port; busy_o/done_o status;
//        errors_o saturating mismatch count; first_err_o index of first mismatch (all-ones if none).
// Build option: FIFO_STREAM_CHECKER_PRBS_EN selects a Galois PRBS expected pattern
//        instead of the incrementing counter.
module fifo_stream_checker
    import fifo_stream_pkg::*;
#(
    parameter int DW         = 16,
    parameter int CNT_W      = 32,
    parameter int ERR_W      = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [7:0]       rate_i,
    output logic             rd_en_o,
    input  logic [DW-1:0]    rd_data_i,
    input  logic             empty_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [ERR_W-1:0] errors_o,
    output logic [CNT_W-1:0] first_err_o
);

    // Any non-zero latency is treated as a registered FIFO output.
    localparam bit LAT0 = (RD_LATENCY == 0);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   remaining_q;
    logic [CNT_W-1:0]   index_q;
    logic [ERR_W-1:0]   errors_q;
    logic [CNT_W-1:0]   first_err_q;
    logic               cmp_valid_q;
    logic [DW-1:0]      expected;
    logic [7:0]         thr_state;
    logic               start_ok;
    logic               in_run;
    logic               request;
    logic               last_rd;
    logic               cmp_fire;
    logic               mismatch;

    assign start_ok = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign in_run   = (state_q == ST_RUN);

    fifo_lfsr #(
        .W      (8),
        .TAPS   (THR_TAPS),
        .SEED   (THR_SEED),
        .GALOIS (1'b0)
    ) u_throttle (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (start_ok),
        .adv_i   (in_run),
        .state_o (thr_state)
    );

    // The LFSR never reaches 0, so rate 0 never requests and rate 255 always does.
    assign request = (thr_state <= rate_i);
    assign rd_en_o = in_run && request && !empty_i && (remaining_q != '0);
    assign last_rd = rd_en_o && (remaining_q == CNT_W'(1));

    // With a registered FIFO the data for a read shows up one cycle later.
    assign cmp_fire = LAT0 ? rd_en_o : cmp_valid_q;
    assign mismatch = cmp_fire && (rd_data_i != expected);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                // remaining==0 in RUN only happens for a zero-length run.
                if (remaining_q == '0) begin
                    state_d = ST_DONE;
                end else if (last_rd) begin
                    state_d = LAT0 ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            remaining_q <= '0;
            index_q     <= '0;
            errors_q    <= '0;
            first_err_q <= '1;
            cmp_valid_q <= 1'b0;
        end else if (start_ok) begin
            remaining_q <= count_i;
            index_q     <= '0;
            errors_q    <= '0;
            first_err_q <= '1;
            cmp_valid_q <= 1'b0;
        end else begin
            cmp_valid_q <= rd_en_o;
            if (rd_en_o) begin
                remaining_q <= remaining_q - CNT_W'(1);
            end
            if (cmp_fire) begin
                index_q <= index_q + CNT_W'(1);
            end
            if (mismatch) begin
                if (errors_q != '1) begin
                    errors_q <= errors_q + ERR_W'(1);
                end
                if (first_err_q == '1) begin
                    first_err_q <= index_q;
                end
            end
        end
    end

`ifdef FIFO_STREAM_CHECKER_PRBS_EN
    localparam logic [63:0]   PRBS_TAPS_64 = prbs_taps(DW);
    localparam logic [DW-1:0] PRBS_TAPS    = PRBS_TAPS_64[DW-1:0];

    // Seeded with all-ones so the first expected word is all-ones.
    fifo_lfsr #(
        .W      (DW),
        .TAPS   (PRBS_TAPS),
        .SEED   ({DW{1'b1}}),
        .GALOIS (1'b1)
    ) u_expected (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (start_ok),
        .adv_i   (cmp_fire),
        .state_o (expected)
    );
`else
    logic [DW-1:0] expected_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            expected_q <= '0;
        end else if (start_ok) begin
            expected_q <= '0;
        end else if (cmp_fire) begin
            expected_q <= expected_q + DW'(1);
        end
    end

    assign expected = expected_q;
`endif

    assign busy_o      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done_o      = (state_q == ST_DONE);
    assign errors_o    = errors_q;
    assign first_err_o = first_err_q;

endmodule

// File: tb/tb_fifo_stream_checker.sv
// tb/tb_fifo_stream_checker.sv - self-checking bench for fifo_stream_checker
module tb_fifo_stream_checker;

    localparam logic [31:0] NO_ERR = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    always #5 clk = ~clk;

    // Main DUT signals
    logic        start = 1'b0;
    logic [31:0] count = '0;
    logic [7:0]  rate = '0;
    logic        rd_en;
    logic [15:0] rd_data = '0;
    logic        empty;
    logic        busy;
    logic        done;
    logic [15:0] errors;
    logic [31:0] first_err;

    // Saturation DUT signals (ERR_W=4), fed a constant wrong word
    logic        sat_start = 1'b0;
    logic [31:0] sat_count = 32'd20;
    logic [7:0]  sat_rate = 8'hFF;
    logic [15:0] sat_data = 16'hDEAD;
    logic        sat_empty = 1'b0;
    logic        sat_rd_en;
    logic        sat_busy;
    logic        sat_done;
    logic [3:0]  sat_errors;
    logic [31:0] sat_first_err;

    fifo_stream_checker #(.DW(16), .CNT_W(32), .ERR_W(16), .RD_LATENCY(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .count_i(count), .rate_i(rate),
        .rd_en_o(rd_en), .rd_data_i(rd_data), .empty_i(empty), .busy_o(busy),
        .done_o(done), .errors_o(errors), .first_err_o(first_err)
    );

    fifo_stream_checker #(.DW(16), .CNT_W(32), .ERR_W(4), .RD_LATENCY(1)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .start_i(sat_start), .count_i(sat_count), .rate_i(sat_rate),
        .rd_en_o(sat_rd_en), .rd_data_i(sat_data), .empty_i(sat_empty), .busy_o(sat_busy),
        .done_o(sat_done), .errors_o(sat_errors), .first_err_o(sat_first_err)
    );

    // Registered-output FIFO model
    logic [15:0] mem [0:1023];
    int          wr_cnt = 0;
    int          rd_ptr = 0;
    logic        flush = 1'b0;
    assign empty = (rd_ptr >= wr_cnt);

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_cnt;
        end else if (rd_en) begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    // Read monitors
    int cyc = 0;
    int rd_cnt = 0;
    int first_rd = 0;
    int last_rd = 0;
    int sat_rd_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (start) begin
            rd_cnt <= 0;
        end else if (rd_en) begin
            if (rd_cnt == 0) first_rd <= cyc;
            last_rd <= cyc;
            rd_cnt  <= rd_cnt + 1;
        end
        if (sat_start) sat_rd_cnt <= 0;
        else if (sat_rd_en) sat_rd_cnt <= sat_rd_cnt + 1;
    end

    // Scoreboard of expected run results
    typedef struct {
        int          errs;
        logic [31:0] first;
        int          reads;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errs_n = 0;

    function automatic logic [15:0] exp_word(input int n);
`ifdef FIFO_STREAM_CHECKER_PRBS_EN
        logic [15:0] s;
        s = 16'hFFFF;
        for (int k = 0; k < n; k++) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
        return s;
`else
        return n[15:0];
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs_n++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill(input int n, input int base, input int bad, input logic [15:0] bad_val);
        for (int i = 0; i < n; i++) begin
            mem[wr_cnt] = (i == bad) ? bad_val : exp_word(base + i);
            wr_cnt++;
        end
    endtask

    task automatic expect_run(input int e, input logic [31:0] f, input int reads);
        exp_t x;
        x.errs  = e;
        x.first = f;
        x.reads = reads;
        sb.push_back(x);
    endtask

    task automatic start_run(input int cnt, input int r);
        count = 32'(cnt);
        rate  = 8'(r);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int budget);
        int   n;
        exp_t x;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 64'(done), 64'(1));
        x = sb.pop_front();
        check({tag, "_errors"}, 64'(errors), 64'(x.errs));
        check({tag, "_first_err"}, 64'(first_err), 64'(x.first));
        check({tag, "_reads"}, 64'(rd_cnt), 64'(x.reads));
        check({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int n;
        int stall_bad;

        #2 rst_n = 1'b0;
        tick(3);
        check("rst_rd_en", 64'(rd_en), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_errors", 64'(errors), 64'(0));
        check("rst_first_err", 64'(first_err), 64'(NO_ERR));
        check("rst_sat_errors", 64'(sat_errors), 64'(0));
        rst_n = 1'b1;
        tick(2);

        // Full rate, 100 words, back-to-back reads
        fill(100, 0, -1, 16'h0);
        expect_run(0, NO_ERR, 100);
        start_run(100, 255);
        finish_run("rate255", 400);
        check("rate255_consecutive", 64'(last_rd - first_rd + 1), 64'(100));

        // Single corrupted word at index 5
        fill(10, 0, 5, 16'hBEEF);
        expect_run(1, 32'd5, 10);
        start_run(10, 255);
        finish_run("corrupt", 200);

        // Empty stall: only 30 of 60 words available at first
        fill(30, 0, -1, 16'h0);
        expect_run(0, NO_ERR, 60);
        start_run(60, 255);
        n = 0;
        while (rd_cnt < 30 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stall_reached", 64'(rd_cnt), 64'(30));
        stall_bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (rd_en !== 1'b0 || busy !== 1'b1) stall_bad++;
            @(negedge clk);
        end
        check("stall_quiet", 64'(stall_bad), 64'(0));
        fill(30, 30, -1, 16'h0);
        finish_run("stall", 300);

        // rate 0 never reads; then raise the rate mid-run
        fill(5, 0, -1, 16'h0);
        expect_run(0, NO_ERR, 5);
        start_run(5, 0);
        tick(200);
        check("rate0_reads", 64'(rd_cnt), 64'(0));
        check("rate0_busy", 64'(busy), 64'(1));
        rate = 8'd128;
        finish_run("rate128", 1000);

        // Zero-length run: done two cycles after the start pulse
        expect_run(0, NO_ERR, 0);
        start_run(0, 255);
        check("zero_done_cleared", 64'(done), 64'(0));
        tick(1);
        check("zero_done", 64'(done), 64'(1));
        finish_run("zero", 5);

        // Reset after 20 of 100 words
        fill(100, 0, -1, 16'h0);
        start_run(100, 255);
        n = 0;
        while (rd_cnt < 20 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("midrst_progress", 64'(rd_cnt), 64'(20));
        check("midrst_busy_before", 64'(busy), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rd_en", 64'(rd_en), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_errors", 64'(errors), 64'(0));
        check("midrst_first_err", 64'(first_err), 64'(NO_ERR));
        @(negedge clk);
        rst_n = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        fill(10, 0, -1, 16'h0);
        expect_run(0, NO_ERR, 10);
        start_run(10, 255);
        finish_run("post_reset", 200);

        // Saturating 4-bit error counter
        sat_start = 1'b1;
        @(negedge clk);
        sat_start = 1'b0;
        n = 0;
        while (!sat_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("sat_done", 64'(sat_done), 64'(1));
        check("sat_errors", 64'(sat_errors), 64'(4'hF));
        check("sat_first_err", 64'(sat_first_err), 64'(0));
        check("sat_reads", 64'(sat_rd_cnt), 64'(20));
        check("sat_busy", 64'(sat_busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errs_n);
        $finish;
    end

endmodule

// File: doc/fifo_stream_checker.md
Name: fifo_stream_checker

Overview:
- Synthesizable read-side traffic checker for the FIFO wrappers: drains a FIFO read port at a programmable random rate and compares each word against the expected sequence the write-side generator produced.
- Counts mismatches and reports the index of the first one.
- Used in hardware self-test builds and in the benches, opposite the write-side stimulus.

Parameters:
- DW, 16, FIFO data width in bits.
- CNT_W, 32, width of the transaction counter and the first-error index.
- ERR_W, 16, width of the saturating error counter.
- RD_LATENCY, 1, read-data latency after rd_en_o: 0 = first-word-fall-through, 1 = registered output.

Ports:
- clk_i  in  1  single clock for all logic.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse that starts a run; ignored while busy_o=1.
- count_i  in  CNT_W  number of words to read; sampled on start.
- rate_i  in  8  read-attempt probability in 256ths; 0 = never, 255 = every cycle.
- rd_en_o  out  1  FIFO read enable; asserted only when empty_i=0.
- rd_data_i  in  DW  FIFO read data.
- empty_i  in  1  FIFO empty flag.
- busy_o  out  1  high from the cycle after start until done.
- done_o  out  1  level; high after a run completes, cleared by the next accepted start.
- errors_o  out  ERR_W  mismatch count, saturating at all-ones.
- first_err_o  out  CNT_W  index of the first mismatching word; holds all-ones if no mismatch.

Behaviour:
- Reset values: rd_en_o=0, busy_o=0, done_o=0, errors_o=0, first_err_o=all-ones. State = IDLE, throttle LFSR = 8'hA5, expected value = 0.
- FSM: IDLE -> RUN on start_i. RUN -> DRAIN when the last rd_en_o is issued (RD_LATENCY=1). RUN -> DONE directly when RD_LATENCY=0. DRAIN -> DONE after one cycle. DONE -> RUN on start_i.
- If start_i arrives with count_i=0, the FSM goes to DONE on the next cycle and issues no reads.
- Accepting a start:
  - latches count_i into the remaining counter;
  - clears errors_o;
  - sets first_err_o to all-ones;
  - resets the word index and expected value to 0;
  - reseeds the LFSR to 8'hA5;
  - clears done_o.
- Throttle: 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, advances every RUN cycle. The LFSR never holds 0. A read request is raised when lfsr <= rate_i.
- rd_en_o = (state==RUN) & request & !empty_i & (remaining!=0). The signal is combinational from state/registers and empty_i.
- Compare timing: the compare happens in the rd_en_o cycle (RD_LATENCY=0) or the following cycle (RD_LATENCY=1), using a registered valid flag.
- Per compare:
  - on a mismatch, errors_o increments (saturating) and first_err_o captures the word index, only while it still holds all-ones;
  - on every compare, the expected value increments modulo 2^DW and the index increments.
- Data pattern: the expected value for word n is n mod 2^DW.
- Reset asserted mid-run: everything returns to reset values immediately. No partial results are retained.
- When empty_i=1, the checker stalls indefinitely with no timeout. rate_i=0 also stalls.
- Changes to rate_i are allowed mid-run and take effect on the next cycle.

Optional Feature:
- Macro FIFO_STREAM_CHECKER_PRBS_EN.
- When defined: the expected pattern is a DW-bit Galois PRBS. It is seeded with all-ones on start and advances once per compare; the first expected word is all-ones.
- When undefined: the expected pattern is the incrementing counter described above.
- The throttle LFSR and all other behaviour are identical in both builds.

Decomposition:
- Package fifo_stream_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the throttle seed 8'hA5 and tap mask;
  - the PRBS tap masks per supported DW.
- One sub-module, fifo_lfsr: parameterised width, taps and seed, with load and advance inputs. It is instantiated once for the throttle and, under the macro, once for the expected pattern.

Test Plan:
- Count and rate: FIFO pre-filled with 0..99, start with count_i=100, rate_i=255, RD_LATENCY=1 -> exactly 100 rd_en_o pulses on consecutive cycles, then done_o=1, errors_o=0, first_err_o=32'hFFFFFFFF.
- Corruption: FIFO filled with 0..9 but word 5 = 16'hBEEF, count_i=10 -> errors_o=1, first_err_o=5.
- Empty stall: empty_i held 1 for 50 cycles mid-run -> rd_en_o=0 throughout, busy_o=1 throughout. After refill, the run completes with errors_o=0.
- Zero cases: rate_i=0 for 200 cycles -> no reads. Start with count_i=0 -> done_o=1 two cycles after start, no reads.
- Reset mid-run: rst_ni low after 20 of 100 words -> all outputs back to reset values asynchronously. A new start then checks from expected value 0.
- Saturation (ERR_W=4 build): 20 mismatching words -> errors_o=4'hF.
